// File: rtl/wb_spram_bridge.sv
// wb_spram_bridge: Wishbone B4 classic slave in front of a single-port
// synchronous RAM (clock/address/data/q/wren/cen). Read and full-word write
// transfers ack after one cycle.
//
// Optional feature macro: WB_SPRAM_BYTE_RMW_EN
//   defined   - partial byte-select writes become a read-modify-write
//               (read in IDLE, merged write in RMW_WR) and ack after two cycles.
//   undefined - partial byte-select writes leave the RAM untouched and
//               terminate with wb_err_o after one cycle.
module wb_spram_bridge #(
    parameter int size       = 'h2000,
    parameter int addr_width = $clog2(size),
    parameter int data_width = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [addr_width-1:0]     wb_adr_i,
    input  logic [data_width-1:0]     wb_dat_i,
    input  logic [data_width/8-1:0]   wb_sel_i,
    output logic [data_width-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [addr_width-1:0]     ram_address,
    output logic [data_width-1:0]     ram_data,
    output logic                      ram_wren,
    output logic                      ram_cen,
    input  logic [data_width-1:0]     ram_q
);

    localparam int sel_width = data_width / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic                    ack_r;
    logic                    err_r;
    logic [addr_width-1:0]   adr_q;
    logic [data_width-1:0]   dat_q;
`ifdef WB_SPRAM_BYTE_RMW_EN
    logic [sel_width-1:0]    sel_q;
`endif

    logic req;
    logic full_sel;

    assign req      = wb_cyc_i & wb_stb_i;
    assign full_sel = &wb_sel_i;

`ifdef WB_SPRAM_BYTE_RMW_EN
    // Byte-lane merge: selected lanes take new data, the rest keep the RAM word.
    function automatic logic [data_width-1:0] byte_merge(
        input logic [data_width-1:0] new_word,
        input logic [data_width-1:0] old_word,
        input logic [sel_width-1:0]  sel
    );
        logic [data_width-1:0] r;
        for (int i = 0; i < sel_width; i++) begin
            r[i*8 +: 8] = sel[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return r;
    endfunction
`endif

    // Read data is the RAM output directly; it is valid in the ack cycle.
    assign wb_dat_o = ram_q;

    // Terminations are suppressed if the master has already dropped the cycle.
    assign wb_ack_o = ack_r & wb_cyc_i;
    assign wb_err_o = err_r & wb_cyc_i;

    // RAM strobes decoded from the state; IDLE uses the live bus request so the
    // access launches on the accept edge, later states use the latched copy.
    always_comb begin
        ram_cen     = 1'b0;
        ram_wren    = 1'b0;
        ram_address = adr_q;
        ram_data    = dat_q;
        case (state)
            IDLE: begin
                ram_address = wb_adr_i;
                ram_data    = wb_dat_i;
                if (req && reset_n) begin
                    if (!wb_we_i) begin
                        ram_cen = 1'b1;
                    end else if (full_sel) begin
                        ram_cen  = 1'b1;
                        ram_wren = 1'b1;
                    end else begin
`ifdef WB_SPRAM_BYTE_RMW_EN
                        // Fetch the old word for the merge.
                        ram_cen = 1'b1;
`endif
                    end
                end
            end
`ifdef WB_SPRAM_BYTE_RMW_EN
            RMW_WR: begin
                if (wb_cyc_i) begin
                    ram_cen  = 1'b1;
                    ram_wren = 1'b1;
                    ram_data = byte_merge(dat_q, ram_q, sel_q);
                end
            end
`endif
            default: ;
        endcase
    end

    // Transfer sequencing and registered ack/err generation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!wb_we_i || full_sel) begin
                            state <= DONE;
                            ack_r <= 1'b1;
                        end else begin
`ifdef WB_SPRAM_BYTE_RMW_EN
                            state <= RMW_WR;
`else
                            state <= DONE;
                            err_r <= 1'b1;
`endif
                        end
                    end
                end
`ifdef WB_SPRAM_BYTE_RMW_EN
                RMW_WR: begin
                    if (wb_cyc_i) begin
                        state <= DONE;
                        ack_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                // DONE never accepts, so a held strobe is not re-issued.
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request on accept for use in later states.
    always_ff @(posedge clock) begin
        if (state == IDLE && req) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
`ifdef WB_SPRAM_BYTE_RMW_EN
            sel_q <= wb_sel_i;
`endif
        end
    end

endmodule

// File: tb/tb_wb_spram_bridge.sv
// tb_wb_spram_bridge: self-checking bench for wb_spram_bridge with a
// behavioural single-port RAM and a response scoreboard.
module tb_wb_spram_bridge;

`ifdef WB_SPRAM_BYTE_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [12:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [12:0] ram_address;
    logic [15:0] ram_data;
    logic        ram_wren, ram_cen;
    logic [15:0] ram_q = '0;

    logic [15:0] mem [0:8191];

    int n_vec  = 0;
    int n_miss = 0;
    int cen_cnt = 0, wren_cnt = 0, ack_cnt = 0, err_cnt = 0;

    typedef struct {
        logic        is_err;
        int          lat;
        logic        chk_dat;
        logic [15:0] dat;
    } exp_t;

    exp_t sb[$];

    wb_spram_bridge dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_cen     (ram_cen),
        .ram_q       (ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural single-port synchronous RAM (read-old-data on write).
    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_q <= mem[ram_address];
        end
    end

    // Event counters.
    always @(posedge clock) begin
        if (ram_cen)  cen_cnt  <= cen_cnt + 1;
        if (ram_wren) wren_cnt <= wren_cnt + 1;
        if (wb_ack_o) ack_cnt  <= ack_cnt + 1;
        if (wb_err_o) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a termination, then pop and compare the expectation.
    task automatic collect(input string tag);
        int   cyc_n = 0;
        exp_t e;
        do begin
            @(negedge clock);
            cyc_n++;
        end while (!(wb_ack_o || wb_err_o) && cyc_n < 8);
        e = sb.pop_front();
        if (!(wb_ack_o || wb_err_o)) begin
            check({tag, "_timeout"}, 32'(wb_ack_o | wb_err_o), 32'd1);
        end else begin
            check({tag, "_err"}, 32'(wb_err_o), 32'(e.is_err));
            check({tag, "_ack"}, 32'(wb_ack_o), 32'(!e.is_err));
            check({tag, "_lat"}, 32'(cyc_n), 32'(e.lat));
            if (e.chk_dat) check({tag, "_dat"}, 32'(wb_dat_o), 32'(e.dat));
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [12:0] adr,
                         input logic [15:0] dat, input logic [1:0] sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic xfer(input string tag, input logic we, input logic [12:0] adr,
                        input logic [15:0] dat, input logic [1:0] sel,
                        input logic ex_err, input int ex_lat, input logic [15:0] ex_dat);
        exp_t e;
        @(negedge clock);
        drive(we, adr, dat, sel);
        e.is_err  = ex_err;
        e.lat     = ex_lat;
        e.chk_dat = !we;
        e.dat     = ex_dat;
        sb.push_back(e);
        collect(tag);
    endtask

    initial begin
        exp_t e;
        int   c0, w0, a0, e0;
        logic prev_ack;

        for (int i = 0; i < 8192; i++) mem[i] = '0;
        reset_n = 1'b0;
        drive(1'b0, 13'h0000, 16'h0000, 2'b11);

        // Reset held with a pending request.
        @(negedge clock);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_cen", 32'(ram_cen), 32'd0);
        reset_n = 1'b1;
        e.is_err = 1'b0; e.lat = 1; e.chk_dat = 1'b1; e.dat = 16'h0000;
        sb.push_back(e);
        collect("rst_first");

        // Full write then read.
        xfer("wr_full", 1'b1, 13'h0010, 16'hBEEF, 2'b11, 1'b0, 1, 16'h0);
        xfer("rd_full", 1'b0, 13'h0010, 16'h0000, 2'b11, 1'b0, 1, 16'hBEEF);

        // Byte-lane writes.
        xfer("pre_1fff", 1'b1, 13'h1FFF, 16'hBEEF, 2'b11, 1'b0, 1, 16'h0);
        xfer("wr_sel01", 1'b1, 13'h1FFF, 16'h12AA, 2'b01, !RMW, RMW ? 2 : 1, 16'h0);
        xfer("rd_sel01", 1'b0, 13'h1FFF, 16'h0000, 2'b11, 1'b0, 1, RMW ? 16'hBEAA : 16'hBEEF);
        xfer("wr_sel10", 1'b1, 13'h1FFF, 16'h5511, 2'b10, !RMW, RMW ? 2 : 1, 16'h0);
        xfer("rd_sel10", 1'b0, 13'h1FFF, 16'h0000, 2'b11, 1'b0, 1, RMW ? 16'h55AA : 16'hBEEF);
        xfer("wr_sel00", 1'b1, 13'h1FFF, 16'hFFFF, 2'b00, !RMW, RMW ? 2 : 1, 16'h0);
        xfer("rd_sel00", 1'b0, 13'h1FFF, 16'h0000, 2'b11, 1'b0, 1, RMW ? 16'h55AA : 16'hBEEF);

        // Held strobe on a read for four cycles.
        @(negedge clock);
        c0 = cen_cnt; a0 = ack_cnt;
        drive(1'b0, 13'h0010, 16'h0000, 2'b11);
        e.is_err = 1'b0; e.lat = 1; e.chk_dat = 1'b1; e.dat = 16'hBEEF;
        sb.push_back(e);
        sb.push_back(e);
        prev_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("hold_consec", 32'(prev_ack & wb_ack_o), 32'd0);
            if ((wb_ack_o || wb_err_o) && sb.size() > 0) begin
                e = sb.pop_front();
                check("hold_dat", 32'(wb_dat_o), 32'(e.dat));
            end
            prev_ack = wb_ack_o;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check("hold_cen", 32'(cen_cnt - c0), 32'd2);
        check("hold_acks", 32'(ack_cnt - a0), 32'd2);
        sb.delete();

        // Abort a partial write by dropping cyc after accept.
        @(negedge clock);
        w0 = wren_cnt; a0 = ack_cnt; e0 = err_cnt;
        drive(1'b1, 13'h0010, 16'h1234, 2'b01);
        @(negedge clock);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_wren", 32'(wren_cnt - w0), 32'd0);
        check("abort_ack", 32'(ack_cnt - a0), 32'd0);
        check("abort_err", 32'(err_cnt - e0), 32'd0);
        xfer("abort_rd", 1'b0, 13'h0010, 16'h0000, 2'b11, 1'b0, 1, 16'hBEEF);

        // Reset asserted in the middle of a partial write.
        @(negedge clock);
        w0 = wren_cnt; a0 = ack_cnt;
        drive(1'b1, 13'h0010, 16'h0000, 2'b01);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_cen", 32'(ram_cen), 32'd0);
        check("midrst_wren", 32'(ram_wren), 32'd0);
        @(negedge clock);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_wcnt", 32'(wren_cnt - w0), 32'd0);
        check("midrst_acnt", 32'(ack_cnt - a0), 32'd0);
        xfer("midrst_rd", 1'b0, 13'h0010, 16'h0000, 2'b11, 1'b0, 1, 16'hBEEF);

        // Top and bottom of the address range do not alias.
        xfer("wrap_wr_hi", 1'b1, 13'h1FFF, 16'hCAFE, 2'b11, 1'b0, 1, 16'h0);
        xfer("wrap_wr_lo", 1'b1, 13'h0000, 16'h0123, 2'b11, 1'b0, 1, 16'h0);
        xfer("wrap_rd_hi", 1'b0, 13'h1FFF, 16'h0000, 2'b11, 1'b0, 1, 16'hCAFE);
        xfer("wrap_rd_lo", 1'b0, 13'h0000, 16'h0000, 2'b11, 1'b0, 1, 16'h0123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
